// File: rtl/fifo_pkg.sv
// Shared FIFO sizing helpers: constant clog2 plus pointer/count width derivations.
package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // One extra bit so the count can represent DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_storage.sv
// WIDTH x DEPTH register array: synchronous write, asynchronous read, no data reset.
module fifo_storage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync.sv
// Synchronous show-ahead FIFO: pointers, occupancy, watermark, flush and sticky error flags.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_data_in,
  input  logic                      i_pop,
  input  logic                      i_flush,
  input  logic                      i_err_clr,
  output logic [WIDTH-1:0]          o_data_out,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_almost_full,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_overflow,
  output logic                      o_underflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_count;
  logic             r_overflow, r_underflow;
  logic             w_full, w_empty;
  logic             w_push_acc, w_pop_acc;
  logic             w_ovf_evt, w_unf_evt;
  logic [WIDTH-1:0] w_rdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees the slot the same-cycle push needs, so full does not block push+pop.
  assign w_push_acc = i_push & (~w_full | i_pop);
  assign w_pop_acc  = i_pop & ~w_empty;
  assign w_ovf_evt  = ~i_flush & i_push & w_full & ~i_pop;
  assign w_unf_evt  = ~i_flush & i_pop & w_empty;

  fifo_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_storage (
    .i_clk   (i_clk),
    .i_we    (w_push_acc & ~i_flush),
    .i_waddr (r_wp),
    .i_wdata (i_data_in),
    .i_raddr (r_rp),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_acc) r_wp <= r_wp + PW'(1);
      if (w_pop_acc)  r_rp <= r_rp + PW'(1);
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_evt | (r_overflow & ~i_err_clr);
      r_underflow <= w_unf_evt | (r_underflow & ~i_err_clr);
    end
  end

  assign o_data_out    = w_empty ? '0 : w_rdata;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_almost_full = (r_count >= CW'(AF_LEVEL));
  assign o_count       = r_count;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: directed vector table, async reset sequence, queue-model random run.
module tb_fifo_sync;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned AF = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         full, empty, afull, ovf, unf;
  logic [2:0]   count;

  int total = 0;
  int bad   = 0;

  fifo_sync #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_push        (push),
    .i_data_in     (din),
    .i_pop         (pop),
    .i_flush       (flush),
    .i_err_clr     (err_clr),
    .o_data_out    (dout),
    .o_full        (full),
    .o_empty       (empty),
    .o_almost_full (afull),
    .o_count       (count),
    .o_overflow    (ovf),
    .o_underflow   (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          p, q, f, c;
    logic [W-1:0] d;
    int          cnt;
    logic [W-1:0] dout;
    bit          fl, em, af, ov, un;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference: contents as a queue, flags as plain bits.
  logic [W-1:0] mq[$];
  bit           m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic [W-1:0] d,
                         input bit fl, input bit em, input bit af, input bit ov, input bit un);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".dout"},  32'(dout),  32'(d));
    chk({tag, ".full"},  32'(full),  32'(fl));
    chk({tag, ".empty"}, 32'(empty), 32'(em));
    chk({tag, ".afull"}, 32'(afull), 32'(af));
    chk({tag, ".ovf"},   32'(ovf),   32'(ov));
    chk({tag, ".unf"},   32'(unf),   32'(un));
  endtask

  task automatic apply(input bit p, input bit q, input bit f, input bit c, input logic [W-1:0] d);
    push = p; pop = q; flush = f; err_clr = c; din = d;
    @(posedge clk);
    #1;
    push = 0; pop = 0; flush = 0; err_clr = 0;
  endtask

  function automatic vec_t mk(bit p, bit q, bit f, bit c, logic [W-1:0] d, int cnt,
                              logic [W-1:0] o, bit fl, bit em, bit af, bit ov, bit un);
    vec_t v;
    v.p = p; v.q = q; v.f = f; v.c = c; v.d = d; v.cnt = cnt; v.dout = o;
    v.fl = fl; v.em = em; v.af = af; v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic model_step(input bit p, input bit q, input bit f, input bit c, input logic [W-1:0] d);
    int  sz;
    bit  oe, ue, pa, qa;
    sz = mq.size();
    oe = !f && p && (sz == int'(D)) && !q;
    ue = !f && q && (sz == 0);
    pa = p && (sz < int'(D) || q);
    qa = q && (sz > 0);
    if (f) mq.delete();
    else begin
      if (qa) void'(mq.pop_front());
      if (pa) mq.push_back(d);
    end
    m_ovf = oe || (m_ovf && !c);
    m_unf = ue || (m_unf && !c);
    apply(p, q, f, c, d);
    sz = mq.size();
    chk_all("model", sz, (sz > 0) ? mq[0] : '0, sz == int'(D), sz == 0,
            sz >= int'(AF), m_ovf, m_unf);
  endtask

  initial begin
    // Directed table: expectations are the state seen after each edge.
    //           p q f c data     cnt dout     fl em af ov un
    vecs.push_back(mk(1,0,0,0,16'h00A0, 1,16'h00A0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,16'h00A1, 2,16'h00A0, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,16'h00A2, 3,16'h00A0, 0,0,1,0,0));
    vecs.push_back(mk(1,0,0,0,16'h00A3, 4,16'h00A0, 1,0,1,0,0));
    vecs.push_back(mk(1,0,0,0,16'hDEAD, 4,16'h00A0, 1,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 3,16'h00A1, 0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 2,16'h00A2, 0,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 1,16'h00A3, 0,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 0,16'h0000, 0,1,0,1,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 0,16'h0000, 0,1,0,1,1));
    vecs.push_back(mk(0,0,0,1,16'h0000, 0,16'h0000, 0,1,0,0,0));
    vecs.push_back(mk(1,1,0,0,16'h0077, 1,16'h0077, 0,0,0,0,1));
    vecs.push_back(mk(0,1,0,0,16'h0000, 0,16'h0000, 0,1,0,0,1));
    vecs.push_back(mk(0,1,0,1,16'h0000, 0,16'h0000, 0,1,0,0,1));
    vecs.push_back(mk(0,0,0,1,16'h0000, 0,16'h0000, 0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,16'h0001, 1,16'h0001, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,16'h0002, 2,16'h0001, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,16'h0003, 3,16'h0001, 0,0,1,0,0));
    vecs.push_back(mk(1,0,0,0,16'h0004, 4,16'h0001, 1,0,1,0,0));
    vecs.push_back(mk(1,1,0,0,16'h0055, 4,16'h0002, 1,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 3,16'h0003, 0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 2,16'h0004, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 1,16'h0055, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 0,16'h0000, 0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,16'h0011, 1,16'h0011, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,16'h0022, 2,16'h0011, 0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,16'h0033, 3,16'h0011, 0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 3,16'h0011, 0,0,1,0,0) );
    vecs[$].d = 16'h0000; vecs[$].p = 0; vecs[$].q = 0; // idle hold, nothing changes
    vecs.push_back(mk(1,0,1,0,16'h0044, 0,16'h0000, 0,1,0,0,0));
    vecs.push_back(mk(1,0,0,0,16'h0099, 1,16'h0099, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,16'h0000, 0,16'h0000, 0,1,0,0,0));

    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_all("reset", 0, '0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, '0);
    chk_all("idle", 0, '0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].p, vecs[i].q, vecs[i].f, vecs[i].c, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout,
              vecs[i].fl, vecs[i].em, vecs[i].af, vecs[i].ov, vecs[i].un);
    end

    // Async reset mid-burst: fill, overflow, then reset between edges with push still high.
    for (int i = 0; i < 5; i++) apply(1, 0, 0, 0, W'(16'h0100 + i));
    chk_all("preRst", 4, 16'h0100, 1, 0, 1, 1, 0);
    push = 1; din = 16'hBEEF;
    #2 rst = 1;
    #1 chk_all("asyncRst", 0, '0, 0, 1, 0, 0, 0);
    push = 0;
    #2 rst = 0;
    @(posedge clk); #1;
    chk_all("postRst", 0, '0, 0, 1, 0, 0, 0);

    mq.delete(); m_ovf = 0; m_unf = 0;

    // Pointer wrap with alternating push/pop.
    for (int v = 1; v <= 10; v++) begin
      model_step(1, 0, 0, 0, W'(v));
      chk("wrapData", 32'(dout), 32'(v));
      chk("wrapCnt",  32'(count), 32'd1);
      model_step(0, 1, 0, 0, '0);
    end

    // Randomised traffic against the queue model.
    for (int n = 0; n < 1500; n++) begin
      model_step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6, W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Parametrised synchronous FIFO with show-ahead output, occupancy count, an almost-full watermark, a synchronous flush and sticky overflow/underflow error flags. It generalises the fixed 4×64-bit FIFO storage to arbitrary width and power-of-two depth and adds full pointer/flag control. It sits between the fetch/memory stages and any consumer needing elastic buffering, such as the instruction queue or write buffer.

## Interface
- `WIDTH`, 64, data word width in bits (≥1)
- `DEPTH`, 4, number of entries; power of two, ≥2
- `AF_LEVEL`, DEPTH-1, `almost_full` asserts when count ≥ AF_LEVEL (1..DEPTH)
- `clk` in 1: the single clock; all state updates on the rising edge
- `rst` in 1: reset, asynchronous and active-high
- `push` in 1: write `data_in` this cycle
- `data_in` in WIDTH: write data
- `pop` in 1: consume the head entry this cycle
- `flush` in 1: synchronous clear of contents
- `err_clr` in 1: synchronous clear of the sticky error flags
- `data_out` out WIDTH: head entry (show-ahead); all zeros when empty
- `full` out 1: count == DEPTH
- `empty` out 1: count == 0
- `almost_full` out 1: count ≥ AF_LEVEL
- `count` out clog2(DEPTH)+1: occupancy, 0..DEPTH
- `overflow` out 1: sticky; a push was rejected
- `underflow` out 1: sticky; a pop was rejected

## Operation
- State: write pointer `wp`, read pointer `rp` (clog2(DEPTH) bits each, wrap modulo DEPTH), `count`, storage array, and the two error flags.
- Push accepted = `push & (~full | pop)`; writes `mem[wp]`, and `wp` increments with wrap.
- Pop accepted = `pop & ~empty`; `rp` increments with wrap.
- `count` next = count + push_acc − pop_acc.
- Full with push and pop together: both are accepted, and count stays at DEPTH.
- Empty with push and pop together: the push is accepted and the pop is rejected. Count becomes 1 and `underflow` sets. There is no fall-through.
- Push while full without pop: the data is dropped, the state is unchanged and `overflow` sets.
- Pop while empty: the state is unchanged and `underflow` sets.
- `flush` takes priority over push and pop. `wp`, `rp` and `count` go to 0. Storage contents are don't-care. Error flags are unaffected.
- `err_clr` clears both flags. If a new error occurs in the same cycle, that flag sets (set wins).
- `data_out` = `mem[rp]` when not empty, else 0. It is combinational from registered state only; there is no combinational path from `push`, `pop` or `data_in`.

## Timing
- Reset (async assert, synchronous release): `wp`=`rp`=`count`=0, `empty`=1, `full`=0, `almost_full`=0 (or 1 if AF_LEVEL==0 is illegal; it is), `overflow`=`underflow`=0, `data_out`=0.
- Write-to-read latency is 1 cycle. A word pushed into an empty FIFO on edge N appears on `data_out` and drops `empty` after edge N.
- Flags and `count` all derive from registered `count` and update together, 1 cycle after the causing edge.
- Error flags assert on the edge following the rejected request.
- Reset asserted mid-operation discards all contents immediately, independent of `clk`.

## Structure
- Shared package `fifo_pkg`: a `clog2` constant function, and the pointer-width and count-width derivations used by all FIFO variants.
- One sub-module, `fifo_storage`: a WIDTH×DEPTH register array with write enable, write address, async read address and no reset on data. It replaces the fixed 4-entry decoder/mux storage.
- Control (pointers, count, flags, errors) lives in the `fifo_sync` top.

## Test plan
- Reset, then idle → `empty`=1, `count`=0, `data_out`=0, and both error flags are 0.
- DEPTH=4, AF_LEVEL=3: push A0..A3 on consecutive cycles → count 1,2,3,4; `almost_full` after the 3rd push; `full` after the 4th; `data_out`=A0 throughout.
- Full, then push 0xDEAD alone → count stays 4 and `overflow`=1. Pop four times → 0xDEAD is never seen and outputs are A0..A3 in order. Then pop on empty → `underflow`=1.
- Pointer wrap: 10 alternating push/pop pairs with values 1..10 → `data_out` matches each value one cycle after its push, and count never exceeds 1.
- Simultaneous events: at full, push+pop of 0x55 → count 4, head advances, and 0x55 emerges after three more pops. At empty, push+pop of 0x77 → count 1, `data_out`=0x77, `underflow`=1.
- Flush with 3 entries plus a concurrent push → count 0 and `empty`=1 next cycle. `err_clr` clears the flags. Async `rst` pulsed mid-burst → outputs return to reset values before the next edge.
